gate_stim_checker: RTL and testbench

GATE_STIM_CHECKER -- requirements
Module: gate_stim_checker

---
 rtl/lab2_pkg.sv | 22 ++
 rtl/sync2.sv | 24 ++
 rtl/gate_stim_checker.sv | 165 ++++++++++++++++
 tb/tb_gate_stim_checker.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lab2_pkg.sv
// Shared constants for the gate stimulus checker: FSM state encoding,
// sweep size and the default settle time.
package lab2_pkg;

  // Sweep FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Two stimulus bits give four vectors, applied in order 00, 01, 10, 11.
  localparam int NUM_VECTORS       = 4;
  localparam int IDX_W             = 2;

  // Default settle time and the counter width that covers the 2..15 range.
  localparam int SETTLE_CYCLES_DEF = 3;
  localparam int SETTLE_CNT_W      = 4;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for the asynchronous gate-network response.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;

  // Shift the asynchronous input through two flops; both clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value and the two stages really form a chain.
    if (!rst_n) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/gate_stim_checker.sv
// Gate stimulus checker: on start, drives the four 2-bit vectors into an
// external two-input gate network, waits SETTLE_CYCLES (2..15) per vector,
// samples the synchronized response and compares it against EXP_TABLE.
// Reports busy/done/pass, a per-vector fail mask and a saturating error count.
// Optional feature: define GLITCH_DET_EN to add the glitch_cnt output, which
// counts changes of the synchronized response late in each settle window.
module gate_stim_checker
  import lab2_pkg::*;
#(
  parameter int                     SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter logic [NUM_VECTORS-1:0] EXP_TABLE     = 4'b1111,
  parameter int                     ERR_W         = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   drv_in1,
  output logic                   drv_in2,
  input  logic                   dut_out,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [NUM_VECTORS-1:0] fail_vec,
  output logic [ERR_W-1:0]       err_cnt
`ifdef GLITCH_DET_EN
  ,
  output logic [ERR_W-1:0]       glitch_cnt
`endif
);

  state_e                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic [SETTLE_CNT_W-1:0] settle_cnt_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    pass_q;
  logic [NUM_VECTORS-1:0]  fail_vec_q;
  logic [NUM_VECTORS-1:0]  fail_vec_d;
  logic [ERR_W-1:0]        err_cnt_q;
  logic [ERR_W-1:0]        err_cnt_d;
  logic                    dut_sync;
  logic                    mismatch;
  logic                    start_acc;

  sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dut_out),
    .q     (dut_sync)
  );

  // A start request is honoured only when no sweep is running.
  assign start_acc = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign mismatch  = (dut_sync != EXP_TABLE[idx_q]);

  // Result of sampling the current vector: mark it failed and bump the
  // error count, holding at all-ones instead of wrapping.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    fail_vec_d = fail_vec_q;
    err_cnt_d  = err_cnt_q;
    if (mismatch) begin
      fail_vec_d[idx_q] = 1'b1;
      if (err_cnt_q != {ERR_W{1'b1}}) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end
  end

  // Sweep FSM with registered outputs; the vector index doubles as the
  // driven stimulus, so it stays at 11 in DONE and is 00 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      settle_cnt_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_vec_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_acc) begin
            state_q    <= ST_DRIVE;
            idx_q      <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_vec_q <= '0;
            err_cnt_q  <= '0;
          end
        end
        ST_DRIVE: begin
          state_q      <= ST_SETTLE;
          settle_cnt_q <= '0;
        end
        ST_SETTLE: begin
          if (settle_cnt_q == SETTLE_CNT_W'(SETTLE_CYCLES - 1)) begin
            state_q <= ST_SAMPLE;
          end else begin
            settle_cnt_q <= settle_cnt_q + 1'b1;
          end
        end
        ST_SAMPLE: begin
          fail_vec_q <= fail_vec_d;
          err_cnt_q  <= err_cnt_d;
          if (idx_q == IDX_W'(NUM_VECTORS - 1)) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (fail_vec_d == '0);
          end else begin
            state_q <= ST_DRIVE;
            idx_q   <= idx_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign drv_in1  = idx_q[1];
  assign drv_in2  = idx_q[0];
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail_vec = fail_vec_q;
  assign err_cnt  = err_cnt_q;

`ifdef GLITCH_DET_EN
  logic             sync_prev_q;
  logic [ERR_W-1:0] glitch_cnt_q;

  // Count response changes once the first two settle cycles of a vector
  // have passed; those early cycles carry the expected synchronizer delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_prev_q  <= 1'b0;
      glitch_cnt_q <= '0;
    end else begin
      sync_prev_q <= dut_sync;
      if (start_acc) begin
        glitch_cnt_q <= '0;
      end else if ((state_q == ST_SETTLE) &&
                   (settle_cnt_q >= SETTLE_CNT_W'(2)) &&
                   (dut_sync != sync_prev_q) &&
                   (glitch_cnt_q != {ERR_W{1'b1}})) begin
        glitch_cnt_q <= glitch_cnt_q + 1'b1;
      end
    end
  end

  assign glitch_cnt = glitch_cnt_q;
`else
  // Glitch detection not built: no counter, no previous-value register.
`endif

endmodule

// File: tb/tb_gate_stim_checker.sv
// Bench for gate_stim_checker. Three instances share clock and reset:
//   u_a: default parameters, response from a selectable gate model
//   u_b: ERR_W=1, response tied low (saturation)
//   u_c: SETTLE_CYCLES=6, EXP_TABLE=0111, NAND response with glitch injection
module tb_gate_stim_checker;

  typedef enum int {M_ONE, M_ZERO, M_NAND, M_AND, M_OR, M_XOR} model_e;

  typedef struct {
    model_e     mode;
    logic [3:0] fv;
    logic [3:0] ec;
    logic       ps;
  } vec_t;

  int     checks   = 0;
  int     failures = 0;
  vec_t   tbl [6];

  logic   clk        = 1'b0;
  logic   rst_n      = 1'b0;
  logic   start      = 1'b0;
  logic   start_c    = 1'b0;
  logic   glitch_inj = 1'b0;
  model_e mode_a     = M_ONE;

  logic       a_in1, a_in2, a_out, busy_a, done_a, pass_a;
  logic [3:0] fv_a, ec_a;
  logic       b_in1, b_in2, busy_b, done_b, pass_b;
  logic [3:0] fv_b;
  logic [0:0] ec_b;
  logic       c_in1, c_in2, c_out, busy_c, done_c, pass_c;
  logic [3:0] fv_c, ec_c;
`ifdef GLITCH_DET_EN
  logic [3:0] gc_a, gc_c;
  logic [0:0] gc_b;
`endif

  always #5 clk = ~clk;

  // Gate network models seen by u_a.
  always_comb begin
    case (mode_a)
      M_ZERO:  a_out = 1'b0;
      M_NAND:  a_out = ~(a_in1 & a_in2);
      M_AND:   a_out = a_in1 & a_in2;
      M_OR:    a_out = a_in1 | a_in2;
      M_XOR:   a_out = a_in1 ^ a_in2;
      default: a_out = 1'b1;
    endcase
  end

  assign c_out = ~(c_in1 & c_in2) ^ glitch_inj;

  gate_stim_checker u_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .drv_in1  (a_in1),
    .drv_in2  (a_in2),
    .dut_out  (a_out),
    .busy     (busy_a),
    .done     (done_a),
    .pass     (pass_a),
    .fail_vec (fv_a),
    .err_cnt  (ec_a)
`ifdef GLITCH_DET_EN
    ,
    .glitch_cnt (gc_a)
`endif
  );

  gate_stim_checker #(.ERR_W(1)) u_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .drv_in1  (b_in1),
    .drv_in2  (b_in2),
    .dut_out  (1'b0),
    .busy     (busy_b),
    .done     (done_b),
    .pass     (pass_b),
    .fail_vec (fv_b),
    .err_cnt  (ec_b)
`ifdef GLITCH_DET_EN
    ,
    .glitch_cnt (gc_b)
`endif
  );

  gate_stim_checker #(.SETTLE_CYCLES(6), .EXP_TABLE(4'b0111)) u_c (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_c),
    .drv_in1  (c_in1),
    .drv_in2  (c_in2),
    .dut_out  (c_out),
    .busy     (busy_c),
    .done     (done_c),
    .pass     (pass_c),
    .fail_vec (fv_c),
    .err_cnt  (ec_c)
`ifdef GLITCH_DET_EN
    ,
    .glitch_cnt (gc_c)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wait (bounded) for done_a; lat counts negedges after the accepting edge.
  task automatic wait_done_a(input int lat0, output int lat);
    lat = lat0;
    while (done_a !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic sweep_a(output int lat);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done_a(0, lat);
  endtask

  // Sweep on u_c; with inject set, dut_out dips low for one cycle inside the
  // vector 1 settle window (vector 1 is driven from edge 8 after acceptance).
  task automatic sweep_c(input bit inject, output int lat);
    @(negedge clk);
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    lat = 0;
    while (done_c !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
      if (inject && lat == 10) glitch_inj = 1'b1;
      if (lat == 11) glitch_inj = 1'b0;
    end
  endtask

  initial begin
    int lat;

    tbl[0] = '{M_ONE,  4'b0000, 4'd0, 1'b1};
    tbl[1] = '{M_NAND, 4'b1000, 4'd1, 1'b0};
    tbl[2] = '{M_ZERO, 4'b1111, 4'd4, 1'b0};
    tbl[3] = '{M_AND,  4'b0111, 4'd3, 1'b0};
    tbl[4] = '{M_OR,   4'b0001, 4'd1, 1'b0};
    tbl[5] = '{M_XOR,  4'b1001, 4'd2, 1'b0};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst drv", 32'({a_in1, a_in2}), 32'd0);
    check("rst busy", 32'(busy_a), 32'd0);
    check("rst done", 32'(done_a), 32'd0);
    check("rst pass", 32'(pass_a), 32'd0);
    check("rst fail_vec", 32'(fv_a), 32'd0);
    check("rst err_cnt", 32'(ec_a), 32'd0);
`ifdef GLITCH_DET_EN
    check("rst glitch_cnt", 32'(gc_a), 32'd0);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle busy", 32'(busy_a), 32'd0);

    // Table-driven sweeps on u_a (u_b follows the same start).
    for (int i = 0; i < 6; i++) begin
      mode_a = tbl[i].mode;
      sweep_a(lat);
      check($sformatf("row%0d latency", i), 32'(lat), 32'd20);
      check($sformatf("row%0d busy", i), 32'(busy_a), 32'd0);
      check($sformatf("row%0d fail_vec", i), 32'(fv_a), 32'(tbl[i].fv));
      check($sformatf("row%0d err_cnt", i), 32'(ec_a), 32'(tbl[i].ec));
      check($sformatf("row%0d pass", i), 32'(pass_a), 32'(tbl[i].ps));
      check($sformatf("row%0d drv held", i), 32'({a_in1, a_in2}), 32'd3);
`ifdef GLITCH_DET_EN
      check($sformatf("row%0d glitch_cnt", i), 32'(gc_a), 32'd0);
`endif
      check($sformatf("row%0d b done", i), 32'(done_b), 32'd1);
      check($sformatf("row%0d b fail_vec", i), 32'(fv_b), 32'hf);
      check($sformatf("row%0d b err_cnt sat", i), 32'(ec_b), 32'd1);
      check($sformatf("row%0d b pass", i), 32'(pass_b), 32'd0);
    end

    // Start pulsed mid-sweep must not restart it.
    mode_a = M_ONE;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done_a(8, lat);
    check("midstart latency", 32'(lat), 32'd20);
    check("midstart pass", 32'(pass_a), 32'd1);

    // Start held high through DONE: back-to-back sweeps.
    mode_a = M_ZERO;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    wait_done_a(0, lat);
    check("held first latency", 32'(lat), 32'd20);
    check("held first fail_vec", 32'(fv_a), 32'hf);
    @(negedge clk);
    check("held restart done", 32'(done_a), 32'd0);
    check("held restart busy", 32'(busy_a), 32'd1);
    check("held restart fail_vec", 32'(fv_a), 32'd0);
    check("held restart err_cnt", 32'(ec_a), 32'd0);
    check("held restart drv", 32'({a_in1, a_in2}), 32'd0);
    wait_done_a(0, lat);
    start = 1'b0;
    check("held second latency", 32'(lat), 32'd20);
    check("held second err_cnt", 32'(ec_a), 32'd4);
    repeat (3) @(negedge clk);
    check("done hold", 32'(done_a), 32'd1);
    check("done hold busy", 32'(busy_a), 32'd0);

    // Reset during vector 2 settle.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("pre-rst drv", 32'({a_in1, a_in2}), 32'd2);
    check("pre-rst fail_vec", 32'(fv_a), 32'h3);
    check("pre-rst err_cnt", 32'(ec_a), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    check("midrst drv", 32'({a_in1, a_in2}), 32'd0);
    check("midrst busy", 32'(busy_a), 32'd0);
    check("midrst done", 32'(done_a), 32'd0);
    check("midrst pass", 32'(pass_a), 32'd0);
    check("midrst fail_vec", 32'(fv_a), 32'd0);
    check("midrst err_cnt", 32'(ec_a), 32'd0);
`ifdef GLITCH_DET_EN
    check("midrst glitch_cnt", 32'(gc_a), 32'd0);
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("postrst busy", 32'(busy_a), 32'd0);
    check("postrst done", 32'(done_a), 32'd0);
    check("postrst drv", 32'({a_in1, a_in2}), 32'd0);
    mode_a = M_ONE;
    sweep_a(lat);
    check("postrst latency", 32'(lat), 32'd20);
    check("postrst pass", 32'(pass_a), 32'd1);

    // Longer settle and non-default expectation table on u_c.
    sweep_c(1'b0, lat);
    check("c latency", 32'(lat), 32'd32);
    check("c pass", 32'(pass_c), 32'd1);
    check("c fail_vec", 32'(fv_c), 32'd0);
    check("c err_cnt", 32'(ec_c), 32'd0);
    sweep_c(1'b1, lat);
    check("c glitch latency", 32'(lat), 32'd32);
    check("c glitch pass", 32'(pass_c), 32'd1);
`ifdef GLITCH_DET_EN
    check("c glitch_cnt", 32'(gc_c), 32'd2);
    sweep_c(1'b0, lat);
    check("c glitch_cnt cleared", 32'(gc_c), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
